seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
- Programmable, parametrised sequence detector for multi-bit symbols.
- Symbols are stepped in one per debounced button press.
- Pattern is loadable at runtime. Overlapping or non-overlapping detection is selectable.
- Provides a match pulse, a saturating match counter and a progress indicator.
- Next-generation replacement for the fixed two-input detector on the board top level.

Parameters:
- SYM_W, 2: symbol width in bits; symbol is {x,y} at default.
- DEPTH, 4: pattern length in symbols; must be >= 2.
- DEBOUNCE_DELAY, 500000: cycles button_sync must stay high before a step; must be >= 2.
- CNT_W, 8: match_count width.
- PATTERN_RST, 8'hFA: pattern after reset; width DEPTH*SYM_W.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- sym_in  input  SYM_W  current symbol; sampled only on a step
- button  input  1  raw asynchronous push-button
- pattern_load  input  1  one-cycle strobe; latches pattern_in
- pattern_in  input  DEPTH*SYM_W  pattern; slice i = i-th symbol in arrival order; slice 0 at LSBs
- overlap_en  input  1  1 = overlapping detection, 0 = history cleared after each match
- match  output  1  one-cycle pulse on detection
- match_count  output  CNT_W  saturating count of matches
- progress  output  $clog2(DEPTH+1)  valid symbols in history, saturating at DEPTH

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - pattern = PATTERN_RST.
  - History, fill, match, match_count all 0.
  - Synchroniser flops and debounce counter 0.
  - Reset mid-press: a step is produced only after button_sync falls and a fresh press completes.
- Debounce:
  - button passes through two flops (button_reg, button_sync).
  - Counter is cleared while button_sync = 0.
  - While button_sync = 1, counter increments until it equals DEBOUNCE_DELAY, then holds.
  - step is asserted combinationally when count == DEBOUNCE_DELAY-1, giving exactly one step per press.
  - A glitch shorter than DEBOUNCE_DELAY-1 cycles of button_sync produces no step.
- History: DEPTH x SYM_W shift register. On a step:
  - h[i] <= h[i+1]; h[DEPTH-1] <= sym_in.
  - fill <= min(fill+1, DEPTH).
- Detection:
  - Condition: fill_next == DEPTH and h_next[i] == pattern[i] for every i.
  - match is registered at the same edge that shifts the history, so it is high for the single cycle after the step edge.
  - Latency: step cycle T → match high in cycle T+1.
- overlap_en = 0: a detecting step sets fill <= 0 instead of incrementing; the history contents remain but are ignored until refilled.
- overlap_en = 1: fill stays at DEPTH, so the next matching symbol can complete a new match.
- match_count increments on each match and saturates at 2^CNT_W-1 (no wrap).
- pattern_load:
  - pattern <= pattern_in; fill <= 0; match <= 0.
  - match_count is unchanged.
  - pattern_load and step in the same cycle: load wins, step is discarded, history is not shifted.
- Precedence: reset > pattern_load > step.
- progress = fill.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package seq_det_pkg:
  - SYM_W default.
  - Named symbol constants: SYM_NONE = 2'b00, SYM_X = 2'b10, SYM_XY = 2'b11.
  - Default PATTERN_RST.
  - Function for progress width.
- Sub-module button_debouncer:
  - Parameter DEBOUNCE_DELAY.
  - Ports: clk, reset, button in; step out.
  - Contains the synchroniser and counter; reusable by other button-driven blocks.
- Top module holds history, fill, pattern register and match logic.

Test Plan (DEBOUNCE_DELAY=4, DEPTH=4, SYM_W=2, CNT_W=4, default pattern 10,10,11,11):
- Press with sym_in = 10,10,11,11, overlap_en = 0 → single match pulse one cycle after the 4th step; match_count = 1; progress = 0.
- button high for only 2 cycles → no step; progress stays 0.
- button held 20 cycles → exactly one step; progress = 1.
- overlap_en = 1, default pattern reloaded as 11,11,11,11, feed seven 11 symbols → matches on steps 4, 5, 6 and 7; match_count = 4.
- overlap_en = 0, same 11 pattern, feed eight 11 symbols → matches on steps 4 and 8 only.
- pattern_load coincident with a step after 3 matching symbols → history not shifted, progress = 0, no match; match_count unchanged.
- Feed 17 matches → match_count saturates at 15.
- Reset asserted mid-sequence with progress = 2 → next cycle progress = 0, match_count = 0, pattern = 8'hFA.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable symbol sequence detector.
// Symbols are {x,y}; the reset pattern is x, x, xy, xy in arrival order.
package seq_det_pkg;

  localparam int SYM_W_DEF = 2;

  localparam logic [SYM_W_DEF-1:0] SYM_NONE = 2'b00;
  localparam logic [SYM_W_DEF-1:0] SYM_X    = 2'b10;
  localparam logic [SYM_W_DEF-1:0] SYM_XY   = 2'b11;

  // Slice 0 (LSBs) is the first symbol to arrive.
  localparam logic [4*SYM_W_DEF-1:0] PATTERN_RST_DEF = {SYM_XY, SYM_XY, SYM_X, SYM_X};

  function automatic int prog_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus hold counter; emits one step per press that
// stays high long enough. A press already held across reset is ignored.
module button_debouncer #(
  parameter int DEBOUNCE_DELAY = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic step
);

  localparam int CW = $clog2(DEBOUNCE_DELAY + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_DELAY);
  localparam logic [CW-1:0] CNT_STEP = CW'(DEBOUNCE_DELAY - 1);

  logic          button_reg_q, button_reg_d;
  logic          button_sync_q, button_sync_d;
  logic          settle_q, settle_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    button_reg_d  = button;
    button_sync_d = button_reg_q;
    settle_d      = 1'b1;
    // Arm only once the synchroniser has shown the button released after reset.
    armed_d       = armed_q | (settle_q & ~button_reg_q & ~button_sync_q);
    cnt_d         = cnt_q;
    if (!button_sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      button_reg_q  <= 1'b0;
      button_sync_q <= 1'b0;
      settle_q      <= 1'b0;
      armed_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      button_reg_q  <= button_reg_d;
      button_sync_q <= button_sync_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
    end
  end

  assign step = armed_q & button_sync_q & (cnt_q == CNT_STEP);

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable sequence detector: debounced steps shift symbols into a history
// that is compared against a runtime-loadable pattern.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                          SYM_W          = SYM_W_DEF,
  parameter int                          DEPTH          = 4,
  parameter int                          DEBOUNCE_DELAY = 500000,
  parameter int                          CNT_W          = 8,
  parameter logic [DEPTH*SYM_W-1:0]      PATTERN_RST    = PATTERN_RST_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SYM_W-1:0]           sym_in,
  input  logic                       button,
  input  logic                       pattern_load,
  input  logic [DEPTH*SYM_W-1:0]     pattern_in,
  input  logic                       overlap_en,
  output logic                       match,
  output logic [CNT_W-1:0]           match_count,
  output logic [prog_w(DEPTH)-1:0]   progress
);

  localparam int PW = prog_w(DEPTH);
  localparam logic [PW-1:0] FILL_MAX = PW'(DEPTH);

  logic                   step;
  logic [SYM_W-1:0]       hist_q [DEPTH];
  logic [SYM_W-1:0]       hist_d [DEPTH];
  logic [PW-1:0]          fill_q, fill_d, fill_inc;
  logic [DEPTH*SYM_W-1:0] pattern_q, pattern_d;
  logic                   match_q, match_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   all_eq, hit;

  button_debouncer #(
    .DEBOUNCE_DELAY(DEBOUNCE_DELAY)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .step  (step)
  );

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    match_d   = 1'b0;
    count_d   = count_q;
    fill_inc  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    all_eq    = 1'b1;
    hit       = 1'b0;

    if (pattern_load) begin
      pattern_d = pattern_in;
      fill_d    = '0;
    end else if (step) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        hist_d[i] = hist_q[i+1];
      end
      hist_d[DEPTH-1] = sym_in;
      // Compare against the post-shift history so match lands with the shift.
      for (int i = 0; i < DEPTH; i++) begin
        if (hist_d[i] != pattern_q[i*SYM_W +: SYM_W]) all_eq = 1'b0;
      end
      hit     = all_eq && (fill_inc == FILL_MAX);
      match_d = hit;
      fill_d  = (hit && !overlap_en) ? '0 : fill_inc;
      if (hit && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q    <= '{default: SYM_NONE};
      fill_q    <= '0;
      pattern_q <= PATTERN_RST;
      match_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      match_q   <= match_d;
      count_q   <= count_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign progress    = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed presses checked every cycle against
// a queue-based model, plus literal checkpoints from hand-worked scenarios.
module tb_seq_pattern_detector;

  localparam int SYM_W = 2;
  localparam int DEPTH = 4;
  localparam int DLY   = 4;
  localparam int CNT_W = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [SYM_W-1:0]       sym_in = '0;
  logic                   button = 1'b0;
  logic                   pattern_load = 1'b0;
  logic [DEPTH*SYM_W-1:0] pattern_in = '0;
  logic                   overlap_en = 1'b0;
  logic                   match;
  logic [CNT_W-1:0]       match_count;
  logic [PW-1:0]          progress;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit checking = 1'b0;

  seq_pattern_detector #(
    .SYM_W(SYM_W), .DEPTH(DEPTH), .DEBOUNCE_DELAY(DLY), .CNT_W(CNT_W),
    .PATTERN_RST(8'hFA)
  ) dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .button(button),
    .pattern_load(pattern_load), .pattern_in(pattern_in), .overlap_en(overlap_en),
    .match(match), .match_count(match_count), .progress(progress)
  );

  always #5 clk = ~clk;

  // Model: a step fires once button has been sampled high DLY edges in a row,
  // taking effect two edges later (synchroniser latency).
  int m_run, m_prev_run, m_fill, m_count;
  bit m_match;
  logic [DEPTH*SYM_W-1:0] m_pat;
  logic [SYM_W-1:0] m_hist[$];

  always @(posedge clk) begin
    bit stp, eq;
    if (reset) begin
      m_run = 0; m_prev_run = 0; m_fill = 0; m_count = 0; m_match = 0;
      m_pat = 8'hFA; m_hist.delete();
    end else begin
      stp = (m_prev_run == DLY);
      m_prev_run = m_run;
      m_run = button ? m_run + 1 : 0;
      m_match = 0;
      if (pattern_load) begin
        m_pat = pattern_in;
        m_fill = 0;
      end else if (stp) begin
        m_hist.push_back(sym_in);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
        eq = (m_fill == DEPTH);
        for (int i = 0; i < m_hist.size(); i++)
          if (m_hist[i] != m_pat[i*SYM_W +: SYM_W]) eq = 0;
        if (eq) begin
          m_match = 1;
          if (m_count < 15) m_count++;
          if (!overlap_en) m_fill = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checks += 3;
      if (match !== m_match) begin
        errors++; $display("FAIL match_cycle: got %0d expected %0d at %0t", match, m_match, $time);
      end
      if (match_count !== CNT_W'(m_count)) begin
        errors++; $display("FAIL count_cycle: got %0d expected %0d at %0t", match_count, m_count, $time);
      end
      if (progress !== PW'(m_fill)) begin
        errors++; $display("FAIL progress_cycle: got %0d expected %0d at %0t", progress, m_fill, $time);
      end
      if (match === 1'b1) pulses++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [SYM_W-1:0] s, input int hold);
    sym_in = s;
    button = 1'b1;
    repeat (hold) @(negedge clk);
    button = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load(input logic [DEPTH*SYM_W-1:0] p);
    pattern_in = p;
    pattern_load = 1'b1;
    @(negedge clk);
    pattern_load = 1'b0;
  endtask

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_count", match_count, 0);
    check("reset_progress", progress, 0);

    // Default pattern 10,10,11,11, non-overlapping
    p0 = pulses;
    press(2'b10, 6); press(2'b10, 6); press(2'b11, 6);
    check("three_progress", progress, 3);
    press(2'b11, 6);
    check("default_pulses", pulses - p0, 1);
    check("default_count", match_count, 1);
    check("default_progress", progress, 0);

    press(2'b01, 2);
    check("glitch_progress", progress, 0);
    press(2'b00, 20);
    check("held_progress", progress, 1);

    // Overlapping, all-11 pattern: seven symbols give four matches
    do_reset();
    overlap_en = 1'b1;
    load(8'hFF);
    p0 = pulses;
    repeat (7) press(2'b11, 6);
    check("ovl_count", match_count, 4);
    check("ovl_pulses", pulses - p0, 4);
    check("ovl_progress", progress, 4);

    // Non-overlapping: eight symbols give two matches
    do_reset();
    overlap_en = 1'b0;
    load(8'hFF);
    p0 = pulses;
    repeat (8) press(2'b11, 6);
    check("novl_count", match_count, 2);
    check("novl_pulses", pulses - p0, 2);

    // Load coincident with the fourth matching step: step is discarded
    repeat (3) press(2'b11, 6);
    check("pre_load_progress", progress, 3);
    p0 = pulses;
    sym_in = 2'b11;
    button = 1'b1;
    repeat (5) @(negedge clk);
    pattern_in = 8'hFF;
    pattern_load = 1'b1;
    @(negedge clk);
    pattern_load = 1'b0;
    button = 1'b0;
    repeat (6) @(negedge clk);
    check("coinc_progress", progress, 0);
    check("coinc_pulses", pulses - p0, 0);
    check("coinc_count", match_count, 2);

    // Saturation: 20 symbols overlapping -> 17 matches, count stops at 15
    do_reset();
    overlap_en = 1'b1;
    load(8'hFF);
    repeat (20) press(2'b11, 6);
    check("sat_count", match_count, 15);

    // Reset mid-sequence restores pattern and clears state
    overlap_en = 1'b0;
    do_reset();
    press(2'b10, 6); press(2'b10, 6);
    check("mid_progress", progress, 2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_progress", progress, 0);
    check("rst_count", match_count, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    press(2'b10, 6); press(2'b10, 6); press(2'b11, 6); press(2'b11, 6);
    check("rst_pattern_count", match_count, 1);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
